// File: rtl/data_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : data_sync                                                     |
// | Brief    : Enable-qualified bus synchronizer; the enable crosses through |
// |            a NUM_STAGES flop chain, and its rise captures the bus once.  |
// |            Optional even-parity check with macro DATA_SYNC_PARITY_EN.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module data_sync #(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  input  logic                 bus_enable,
`ifdef DATA_SYNC_PARITY_EN
  input  logic                 unsync_parity,
  output logic                 parity_err,
`endif
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 enable_pulse
);

  logic [NUM_STAGES-1:0] r_sync;
  logic                  r_pulse_gen;
  logic [BUS_WIDTH-1:0]  r_sync_bus;
  logic                  r_enable_pulse;
  logic                  w_rise;
  logic                  w_parity_ok;

  assign w_rise = r_sync[NUM_STAGES-1] & ~r_pulse_gen;

`ifdef DATA_SYNC_PARITY_EN
  logic r_parity_err;

  // Even parity: data bits plus parity bit must XOR to zero.
  assign w_parity_ok = ~(^{unsync_bus, unsync_parity});

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_rise & ~w_parity_ok;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign w_parity_ok = 1'b1;
`endif

  // Only the enable is synchronized; the bus is sampled directly on the rise,
  // relying on the source holding it stable while the enable is high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync         <= '0;
      r_pulse_gen    <= 1'b0;
      r_sync_bus     <= '0;
      r_enable_pulse <= 1'b0;
    end else begin
      r_sync         <= {r_sync[NUM_STAGES-2:0], bus_enable};
      r_pulse_gen    <= r_sync[NUM_STAGES-1];
      r_enable_pulse <= w_rise & w_parity_ok;
      if (w_rise && w_parity_ok) begin
        r_sync_bus <= unsync_bus;
      end
    end
  end

  assign sync_bus     = r_sync_bus;
  assign enable_pulse = r_enable_pulse;

endmodule
`default_nettype wire

// File: tb/tb_data_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_data_sync                                                  |
// | Brief    : Directed bench for data_sync (default and 4-stage/16-bit).    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_data_sync;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  bus = 8'h00;
  logic        en  = 1'b0;
  logic [7:0]  sbus;
  logic        pulse;
  logic [15:0] bus4 = 16'h0000;
  logic        en4  = 1'b0;
  logic [15:0] sbus4;
  logic        pulse4;
`ifdef DATA_SYNC_PARITY_EN
  logic        par  = 1'b0;
  logic        perr;
  logic        par4 = 1'b0;
  logic        perr4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  data_sync #(.NUM_STAGES(2), .BUS_WIDTH(8)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .unsync_bus   (bus),
    .bus_enable   (en),
`ifdef DATA_SYNC_PARITY_EN
    .unsync_parity(par),
    .parity_err   (perr),
`endif
    .sync_bus     (sbus),
    .enable_pulse (pulse)
  );

  data_sync #(.NUM_STAGES(4), .BUS_WIDTH(16)) dut4 (
    .CLK          (CLK),
    .RST          (RST),
    .unsync_bus   (bus4),
    .bus_enable   (en4),
`ifdef DATA_SYNC_PARITY_EN
    .unsync_parity(par4),
    .parity_err   (perr4),
`endif
    .sync_bus     (sbus4),
    .enable_pulse (pulse4)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        en  = 1'b1;
        bus = 8'hFF;
      end
      step();
      checks++;
      if (pulse !== 1'b0 || sbus !== 8'h00) begin
        errors++;
        $display("FAIL reset_state cyc%0d: pulse=%b sync_bus=%h, want 0/00", i, pulse, sbus);
      end
      checks++;
      if (pulse4 !== 1'b0 || sbus4 !== 16'h0000) begin
        errors++;
        $display("FAIL reset_state_w cyc%0d: pulse=%b sync_bus=%h, want 0/0000", i, pulse4, sbus4);
      end
`ifdef DATA_SYNC_PARITY_EN
      checks++;
      if (perr !== 1'b0) begin
        errors++;
        $display("FAIL reset_perr: got %b want 0", perr);
      end
`endif
    end
    RST = 1'b0;
    en  = 1'b0;
    bus = 8'h00;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (pulse !== 1'b0 || sbus !== 8'h00) begin
        errors++;
        $display("FAIL post_reset_idle cyc%0d: pulse=%b sync_bus=%h, want 0/00", i, pulse, sbus);
      end
    end
  endtask

  task automatic test_latency();
    bus = 8'hA5;
    en  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (pulse !== (i == 3) || sbus !== ((i == 3) ? 8'hA5 : 8'h00)) begin
        errors++;
        $display("FAIL latency edge%0d: pulse=%b sync_bus=%h, want %b/%h",
                 i, pulse, sbus, (i == 3), ((i == 3) ? 8'hA5 : 8'h00));
      end
    end
  endtask

  task automatic test_hold();
    int cnt;
    cnt = 0;
    for (int i = 0; i < 17; i++) begin
      step();
      if (pulse === 1'b1) cnt++;
    end
    checks++;
    if (cnt !== 0 || sbus !== 8'hA5) begin
      errors++;
      $display("FAIL hold_high: extra pulses=%0d sync_bus=%h, want 0/a5", cnt, sbus);
    end
    en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (pulse === 1'b1) cnt++;
    end
    checks++;
    if (cnt !== 0 || sbus !== 8'hA5) begin
      errors++;
      $display("FAIL fall_no_pulse: pulses=%0d sync_bus=%h, want 0/a5", cnt, sbus);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [3];
    int cnt;
    int at;
    vals[0] = 8'h3C;
    vals[1] = 8'hC3;
    vals[2] = 8'hFF;
    for (int t = 0; t < 3; t++) begin
      cnt = 0;
      at  = -1;
      bus = vals[t];
      en  = 1'b1;
      for (int i = 1; i <= 4; i++) begin
        step();
        if (pulse === 1'b1) begin
          cnt++;
          at = i;
        end
      end
      en = 1'b0;
      for (int i = 5; i <= 8; i++) begin
        step();
        if (pulse === 1'b1) cnt++;
      end
      checks++;
      if (cnt !== 1 || at !== 3 || sbus !== vals[t]) begin
        errors++;
        $display("FAIL b2b xfer%0d: pulses=%0d at_edge=%0d sync_bus=%h, want 1/3/%h",
                 t, cnt, at, sbus, vals[t]);
      end
    end
  endtask

  task automatic test_reset_abort();
    bus = 8'h5A;
    en  = 1'b1;
    step();
    RST = 1'b1;
    step();
    checks++;
    if (pulse !== 1'b0 || sbus !== 8'h00) begin
      errors++;
      $display("FAIL abort_reset: pulse=%b sync_bus=%h, want 0/00", pulse, sbus);
    end
    step();
    checks++;
    if (pulse !== 1'b0 || sbus !== 8'h00) begin
      errors++;
      $display("FAIL abort_reset_hold: pulse=%b sync_bus=%h, want 0/00", pulse, sbus);
    end
    RST = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (pulse !== (i == 3) || sbus !== ((i >= 3) ? 8'h5A : 8'h00)) begin
        errors++;
        $display("FAIL rerise edge%0d: pulse=%b sync_bus=%h, want %b/%h",
                 i, pulse, sbus, (i == 3), ((i >= 3) ? 8'h5A : 8'h00));
      end
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) step();
  endtask

`ifdef DATA_SYNC_PARITY_EN
  task automatic test_parity();
    bus = 8'h01;
    par = 1'b1;
    en  = 1'b1;
    for (int i = 1; i <= 3; i++) step();
    checks++;
    if (pulse !== 1'b1 || perr !== 1'b0 || sbus !== 8'h01) begin
      errors++;
      $display("FAIL parity_good: pulse=%b perr=%b sync_bus=%h, want 1/0/01", pulse, perr, sbus);
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) step();
    bus = 8'h01;
    par = 1'b0;
    en  = 1'b1;
    for (int i = 1; i <= 3; i++) step();
    checks++;
    if (pulse !== 1'b0 || perr !== 1'b1 || sbus !== 8'h01) begin
      errors++;
      $display("FAIL parity_bad: pulse=%b perr=%b sync_bus=%h, want 0/1/01", pulse, perr, sbus);
    end
    step();
    checks++;
    if (perr !== 1'b0) begin
      errors++;
      $display("FAIL parity_err_width: perr=%b want 0", perr);
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) step();
  endtask
`endif

  task automatic test_wide();
    bus4 = 16'hBEEF;
    en4  = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      checks++;
      if (pulse4 !== (i == 5) || sbus4 !== ((i >= 5) ? 16'hBEEF : 16'h0000)) begin
        errors++;
        $display("FAIL wide edge%0d: pulse=%b sync_bus=%h, want %b/%h",
                 i, pulse4, sbus4, (i == 5), ((i >= 5) ? 16'hBEEF : 16'h0000));
      end
    end
    en4 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_hold();
    test_back_to_back();
    test_reset_abort();
`ifdef DATA_SYNC_PARITY_EN
    test_parity();
`endif
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
